// File: rtl/serial_work_receiver_pkg.sv
// Shared definitions for the serial work receiver.
// Holds the default frame geometry and timeout, the field offsets of the
// assembled work word as used by the miner top, and a helper that returns
// the number of bytes on the wire for one frame.
package serial_work_receiver_pkg;

    localparam int          DEF_FRAME_BYTES = 52;
    localparam logic [23:0] DEF_TIMEOUT     = 24'h800000;

    // Field layout of the 52-byte work word (first received byte in MSBs).
    localparam int TARGET_MSB = 415;
    localparam int TARGET_LSB = 384;
    localparam int DATA2_MSB  = 383;
    localparam int DATA2_LSB  = 256;
    localparam int DATA1_MSB  = 255;
    localparam int DATA1_LSB  = 0;

    // Bytes on the wire per frame: payload plus optional XOR checksum byte.
    function automatic int frame_len(input int frame_bytes, input bit use_csum);
        return frame_bytes + (use_csum ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_work_receiver_work_fifo.sv
// work_fifo: show-ahead synchronous FIFO for assembled work frames.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   rdata           head entry, valid while !empty; forced to 0 when empty
//   full, empty     occupancy flags
//   level           number of stored entries, 0..DEPTH
module work_fifo
    import serial_work_receiver_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage is not reset; the empty gate below keeps the output clean.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/serial_work_receiver.sv
// serial_work_receiver: assembles fixed-length work frames from a byte
// stream, checks an optional trailing XOR checksum, discards stalled
// partial frames after an idle timeout, and queues good frames in a
// show-ahead FIFO drained with a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_valid, rx_byte          one-cycle byte strobe and data from the UART
//   work_data, work_valid      head-of-FIFO frame (first byte in MSBs), non-empty
//   work_ready                 consumer accepts head when work_valid & work_ready
//   rx_done                    pulse: frame written to the FIFO
//   err_timeout                pulse: partial frame discarded after idle timeout
//   err_checksum               pulse: frame discarded on checksum mismatch
//   err_overflow               pulse: good frame dropped because FIFO was full
//   level                      FIFO occupancy
module serial_work_receiver
    import serial_work_receiver_pkg::*;
#(
    parameter int                 FRAME_BYTES  = DEF_FRAME_BYTES,
    parameter int                 USE_CHECKSUM = 1,
    parameter int                 TIMER_W      = 24,
    parameter logic [TIMER_W-1:0] TIMEOUT      = TIMER_W'(DEF_TIMEOUT),
    parameter int                 DEPTH        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic [8*FRAME_BYTES-1:0] work_data,
    output logic                     work_valid,
    input  logic                     work_ready,
    output logic                     rx_done,
    output logic                     err_timeout,
    output logic                     err_checksum,
    output logic                     err_overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int W     = 8 * FRAME_BYTES;
    localparam int CNT_W = $clog2(frame_len(FRAME_BYTES, USE_CHECKSUM != 0));
    localparam logic [CNT_W-1:0]   LAST_PAYLOAD = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0]   CSUM_IDX     = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0]   CNT_ONE      = 1;
    localparam logic [TIMER_W-1:0] TIMER_ONE    = 1;

    logic [CNT_W-1:0]   cnt_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [7:0]         csum_reg;
    logic [W-1:0]       frame_sr_reg;
    logic               commit_pend_reg;
    logic               csum_bad_reg;
    logic               rx_done_reg;
    logic               err_timeout_reg;
    logic               err_checksum_reg;
    logic               err_overflow_reg;

    logic csum_byte;
    logic last_payload;
    logic timeout_hit;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic commit_write;

    // Which byte closes the frame depends on whether a checksum trails it.
    generate
        if (USE_CHECKSUM != 0) begin : g_csum
            assign csum_byte    = (cnt_reg == CSUM_IDX);
            assign last_payload = 1'b0;
        end else begin : g_no_csum
            assign csum_byte    = 1'b0;
            assign last_payload = (cnt_reg == LAST_PAYLOAD);
        end
    endgenerate

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit  = ~rx_valid && (cnt_reg != '0) && (timer_reg == TIMEOUT);
    assign work_valid   = ~fifo_empty;
    assign pop          = work_valid & work_ready;
    assign commit_write = commit_pend_reg & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg          <= '0;
            timer_reg        <= '0;
            csum_reg         <= '0;
            frame_sr_reg     <= '0;
            commit_pend_reg  <= 1'b0;
            csum_bad_reg     <= 1'b0;
            rx_done_reg      <= 1'b0;
            err_timeout_reg  <= 1'b0;
            err_checksum_reg <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            commit_pend_reg  <= 1'b0;
            csum_bad_reg     <= 1'b0;
            rx_done_reg      <= commit_write;
            err_overflow_reg <= commit_pend_reg & ~commit_write;
            err_checksum_reg <= csum_bad_reg;
            err_timeout_reg  <= timeout_hit;

            if (rx_valid) begin
                timer_reg <= '0;
                if (csum_byte) begin
                    // Checksum byte is compared, never shifted in.
                    cnt_reg         <= '0;
                    csum_reg        <= '0;
                    commit_pend_reg <= (rx_byte == csum_reg);
                    csum_bad_reg    <= (rx_byte != csum_reg);
                end else begin
                    // In the commit cycle this shift lands on the same edge
                    // as the FIFO write, which still captures the old frame.
                    frame_sr_reg <= W'({frame_sr_reg, rx_byte});
                    if (last_payload) begin
                        cnt_reg         <= '0;
                        csum_reg        <= '0;
                        commit_pend_reg <= 1'b1;
                    end else begin
                        cnt_reg  <= cnt_reg + CNT_ONE;
                        csum_reg <= csum_reg ^ rx_byte;
                    end
                end
            end else if (cnt_reg != '0) begin
                if (timeout_hit) begin
                    cnt_reg   <= '0;
                    csum_reg  <= '0;
                    timer_reg <= '0;
                end else begin
                    timer_reg <= timer_reg + TIMER_ONE;
                end
            end
        end
    end

    work_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (commit_pend_reg),
        .wdata (frame_sr_reg),
        .pop   (pop),
        .rdata (work_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign rx_done      = rx_done_reg;
    assign err_timeout  = err_timeout_reg;
    assign err_checksum = err_checksum_reg;
    assign err_overflow = err_overflow_reg;

endmodule

// File: tb/tb_serial_work_receiver.sv
module tb_serial_work_receiver;

    localparam int FB    = 52;
    localparam int W     = 8 * FB;
    localparam int TO    = 100;
    localparam int DEPTH = 2;

    localparam logic [3:0] EV_DONE = 4'b0001;
    localparam logic [3:0] EV_OVF  = 4'b0010;
    localparam logic [3:0] EV_CSUM = 4'b0100;
    localparam logic [3:0] EV_TO   = 4'b1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         work_ready = 1'b0;
    logic [W-1:0] work_data;
    logic         work_valid;
    logic         rx_done;
    logic         err_timeout;
    logic         err_checksum;
    logic         err_overflow;
    logic [1:0]   level;

    always #5 clk = ~clk;

    serial_work_receiver #(
        .FRAME_BYTES  (FB),
        .USE_CHECKSUM (1),
        .TIMER_W      (24),
        .TIMEOUT      (24'(TO)),
        .DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .work_data    (work_data),
        .work_valid   (work_valid),
        .work_ready   (work_ready),
        .rx_done      (rx_done),
        .err_timeout  (err_timeout),
        .err_checksum (err_checksum),
        .err_overflow (err_overflow),
        .level        (level)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    typedef struct {
        longint     cyc;
        logic [3:0] kind;
    } ev_t;

    logic [7:0]   cur_q[$];          // bytes of the frame in progress
    int           idle_cnt = 0;      // idle cycles since last byte, mid-frame
    bit           pend_commit = 0;
    bit           pend_bad = 0;
    logic [W-1:0] pend_data;
    int           model_occ = 0;     // predicted FIFO occupancy
    logic [W-1:0] exp_frames[$];     // frames expected to leave the FIFO, in order
    ev_t          ev_q[$];           // expected status pulses
    longint       cyc = 0;

    task automatic model_clear();
        cur_q.delete();
        idle_cnt    = 0;
        pend_commit = 0;
        pend_bad    = 0;
        model_occ   = 0;
        exp_frames.delete();
        ev_q.delete();
    endtask

    task automatic model_step();
        logic [3:0]   ev;
        bit           pop_now;
        logic [7:0]   x;
        logic [W-1:0] d;
        ev_t          e;
        ev      = 4'b0000;
        pop_now = (model_occ > 0) && work_ready;
        if (pend_commit) begin
            if (model_occ < DEPTH || pop_now) begin
                exp_frames.push_back(pend_data);
                model_occ++;
                ev = EV_DONE;
            end else begin
                ev = EV_OVF;
            end
            pend_commit = 0;
        end
        if (pop_now) model_occ--;
        if (pend_bad) begin
            ev       = EV_CSUM;
            pend_bad = 0;
        end
        if (rx_valid) begin
            cur_q.push_back(rx_byte);
            idle_cnt = 0;
            if (cur_q.size() == FB + 1) begin
                x = 8'h00;
                d = '0;
                for (int i = 0; i < FB; i++) begin
                    x ^= cur_q[i];
                    d[W-1-8*i -: 8] = cur_q[i];
                end
                if (x == cur_q[FB]) begin
                    pend_commit = 1;
                    pend_data   = d;
                end else begin
                    pend_bad = 1;
                end
                cur_q.delete();
            end
        end else if (cur_q.size() != 0) begin
            if (idle_cnt == TO) begin
                cur_q.delete();
                idle_cnt = 0;
                ev = EV_TO;
            end else begin
                idle_cnt++;
            end
        end
        if (ev != 4'b0000) begin
            e.cyc  = cyc;
            e.kind = ev;
            ev_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_clear();
            else        model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [3:0]   exp_k;
        logic [3:0]   act;
        logic [W-1:0] d;
        int           npop;
        npop = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_flags", {rx_done, err_timeout, err_checksum, err_overflow, work_valid, level}, '0);
                check("reset_data", work_data, '0);
            end else begin
                while (ev_q.size() != 0 && ev_q[0].cyc < cyc) begin
                    check("missed_pulse", '0, ev_q[0].kind);
                    void'(ev_q.pop_front());
                end
                exp_k = 4'b0000;
                if (ev_q.size() != 0 && ev_q[0].cyc == cyc) exp_k = ev_q[0].kind;
                act = {err_timeout, err_checksum, err_overflow, rx_done};
                if (act != 4'b0000 || exp_k != 4'b0000) begin
                    check("pulses", act, exp_k);
                    if (exp_k != 4'b0000) void'(ev_q.pop_front());
                end
                check("level", level, model_occ);
                if (work_valid && work_ready) begin
                    if (exp_frames.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got frame %h expected no frame", work_data);
                    end else begin
                        d = exp_frames.pop_front();
                        check("pop_data", work_data, d);
                        npop++;
                        $display("pop %0d: head bytes %h..%h", npop, work_data[W-1 -: 16], work_data[15:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit         rand_ready = 0;
    logic [7:0] fb[FB];

    task automatic cyc1(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        if (rand_ready) work_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1(1'b0, 8'h00);
    endtask

    task automatic fill_seq();
        for (int i = 0; i < FB; i++) fb[i] = 8'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < FB; i++) fb[i] = 8'($urandom_range(0, 255));
    endtask

    // Sends the payload in fb[] then its checksum; returns just after the
    // edge that sampled the checksum byte (the commit cycle).
    task automatic send_frame(input bit corrupt, input int max_gap);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < FB; i++) begin
            cyc1(1'b1, fb[i]);
            x ^= fb[i];
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        cyc1(1'b1, corrupt ? (x ^ 8'h01) : x);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_clear();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Directed: counting frame with correct checksum 0x34, consumer stalled.
        fill_seq();
        send_frame(1'b0, 0);
        idle(1);
        check("t1_rx_done", rx_done, 1'b1);
        check("t1_level", level, 2'd1);
        check("t1_valid", work_valid, 1'b1);
        check("t1_first_byte", work_data[W-1 -: 8], 8'h01);
        check("t1_last_byte", work_data[7:0], 8'h34);
        work_ready = 1'b1;
        idle(3);
        check("t1_drained", level, 2'd0);

        // Directed: corrupted checksum, then a good frame.
        send_frame(1'b1, 0);
        idle(2);
        check("t2_level", level, 2'd0);
        fill_rand();
        send_frame(1'b0, 2);
        idle(3);

        // Directed: partial frame times out, next frame intact.
        for (int i = 0; i < 10; i++) cyc1(1'b1, 8'($urandom_range(0, 255)));
        idle(TO + 10);
        fill_rand();
        send_frame(1'b0, 0);
        idle(3);

        // Directed: overflow on the third frame, then ordered drain.
        work_ready = 1'b0;
        repeat (3) begin
            fill_rand();
            send_frame(1'b0, 1);
        end
        idle(2);
        check("t4_level_full", level, 2'd2);
        work_ready = 1'b1;
        idle(4);

        // Directed: full FIFO, pop during the commit cycle.
        work_ready = 1'b0;
        repeat (2) begin
            fill_rand();
            send_frame(1'b0, 0);
        end
        idle(2);
        fill_rand();
        send_frame(1'b0, 0);
        work_ready = 1'b1;
        idle(1);
        work_ready = 1'b0;
        check("t5_level", level, 2'd2);
        check("t5_rx_done", rx_done, 1'b1);
        work_ready = 1'b1;
        idle(4);

        // Directed: reset mid-frame with one entry queued.
        work_ready = 1'b0;
        fill_rand();
        send_frame(1'b0, 0);
        idle(2);
        check("t6_level_before", level, 2'd1);
        for (int i = 0; i < 20; i++) cyc1(1'b1, 8'($urandom_range(0, 255)));
        do_reset(3);
        idle(1);
        check("t6_level_after", level, 2'd0);
        fill_rand();
        send_frame(1'b0, 0);
        idle(1);
        check("t6_rx_done", rx_done, 1'b1);
        work_ready = 1'b1;
        idle(3);

        // Randomised traffic with random consumer back-pressure.
        rand_ready = 1;
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                repeat ($urandom_range(1, 20)) cyc1(1'b1, 8'($urandom_range(0, 255)));
                idle(TO + 1 + $urandom_range(0, 3));
            end else begin
                fill_rand();
                send_frame(r == 1, (r < 4) ? 0 : 3);
                idle($urandom_range(0, 2));
            end
        end
        rand_ready = 0;
        work_ready = 1'b1;
        idle(10);
        check("end_frames_left", exp_frames.size(), 0);
        check("end_events_left", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
